// File: rtl/rsa_job_sched.sv
// Job scheduler for two RSA engine wrappers: a CSR-fed descriptor FIFO
// dispatched round-robin, with a completion counter, sticky error flags and an interrupt.
module rsa_job_sched #(
  parameter int QDEPTH = 4,
  parameter int NENG   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      avs_address,
  input  logic            avs_read,
  input  logic            avs_write,
  input  logic [31:0]     avs_writedata,
  output logic [31:0]     avs_readdata,
  output logic            avs_waitrequest,
  output logic [NENG-1:0] eng_start,
  output logic [31:0]     eng_src,
  output logic [31:0]     eng_dst,
  output logic [7:0]      eng_len,
  input  logic [NENG-1:0] eng_done,
  output logic            irq
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_DISPATCH} state_t;

  state_t state_q, state_d;

  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [7:0]      len_q, len_d;
  logic            enable_q, enable_d;
  logic            irq_en_q, irq_en_d;
  logic            irq_q, irq_d;
  logic            ovf_q, ovf_d;
  logic            zl_q, zl_d;
  logic            sp_q, sp_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [NENG-1:0] busy_q, busy_d;
  logic            rr_q, rr_d;
  logic            sel_q, sel_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   qcnt_q, qcnt_d;
  logic [NENG-1:0] start_q, start_d;
  logic [31:0]     esrc_q, esrc_d;
  logic [31:0]     edst_q, edst_d;
  logic [7:0]      elen_q, elen_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [71:0]     mem [QDEPTH];
  logic [71:0]     head;

  logic            go, pop, full, empty, sel_pick;
  logic            ctrl_wr, push_req, clear, push_ok, push_ovf, push_zero;
  logic [NENG-1:0] done_ok, done_sp;
  logic [1:0]      inc;
  logic [31:0]     status;

  assign full      = (qcnt_q == CW'(QDEPTH));
  assign empty     = (qcnt_q == '0);
  assign pop       = (state_q == S_DISPATCH);
  assign head      = mem[rd_ptr_q];
  assign sel_pick  = busy_q[rr_q] ? ~rr_q : rr_q;

  assign ctrl_wr   = avs_write && (avs_address == 3'd3);
  assign push_req  = ctrl_wr && avs_writedata[0];
  assign clear     = ctrl_wr && avs_writedata[2];
  assign push_zero = push_req && (len_q == 8'd0);
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign push_ok   = push_req && (len_q != 8'd0) && (!full || pop);
  assign push_ovf  = push_req && (len_q != 8'd0) && full && !pop;

  genvar gi;
  generate
    for (gi = 0; gi < NENG; gi++) begin : g_eng
      assign done_ok[gi] = eng_done[gi] & busy_q[gi];
      assign done_sp[gi] = eng_done[gi] & ~busy_q[gi];
      assign busy_d[gi]  = (busy_q[gi] & ~done_ok[gi]) | (pop && (sel_q == 1'(gi)));
    end
  endgenerate

  assign inc = {1'b0, done_ok[0]} + {1'b0, done_ok[1]};

  assign status = {18'd0, sp_q, zl_q, ovf_q, irq_q, enable_q, busy_q,
                   empty, full, 5'(qcnt_q)};

  // FSM next state
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_q && !empty && (busy_q != {NENG{1'b1}})) begin
          go      = 1'b1;
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and CSR next state
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    rr_d     = rr_q;
    sel_d    = sel_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    qcnt_d   = qcnt_q;
    start_d  = '0;
    esrc_d   = esrc_q;
    edst_d   = edst_q;
    elen_d   = elen_q;
    rdata_d  = rdata_q;

    if (avs_write) begin
      case (avs_address)
        3'd0: src_d = avs_writedata;
        3'd1: dst_d = avs_writedata;
        3'd2: len_d = avs_writedata[7:0];
        3'd3: begin
          enable_d = avs_writedata[1];
          irq_en_d = avs_writedata[3];
        end
        default: ;
      endcase
    end

    if (avs_read) begin
      case (avs_address)
        3'd0:    rdata_d = src_q;
        3'd1:    rdata_d = dst_q;
        3'd2:    rdata_d = {24'd0, len_q};
        3'd4:    rdata_d = status;
        3'd5:    rdata_d = {16'd0, cnt_q};
        default: rdata_d = 32'd0;
      endcase
    end

    // Descriptor is captured while deciding, so it is stable during the start pulse.
    if (go) begin
      start_d[sel_pick] = 1'b1;
      sel_d  = sel_pick;
      esrc_d = head[71:40];
      edst_d = head[39:8];
      elen_d = head[7:0];
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rr_d     = ~sel_q;
    end
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   qcnt_d = qcnt_q + 1'b1;
      2'b01:   qcnt_d = qcnt_q - 1'b1;
      default: qcnt_d = qcnt_q;
    endcase

    cnt_d = (clear ? 16'd0 : cnt_q) + {14'd0, inc};
    irq_d = (clear ? 1'b0 : irq_q) | ((inc != 2'd0) && irq_en_q);
    ovf_d = (clear ? 1'b0 : ovf_q) | push_ovf;
    zl_d  = (clear ? 1'b0 : zl_q)  | push_zero;
    sp_d  = (clear ? 1'b0 : sp_q)  | (done_sp != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      zl_q     <= 1'b0;
      sp_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= '0;
      rr_q     <= 1'b0;
      sel_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      qcnt_q   <= '0;
      start_q  <= '0;
      esrc_q   <= '0;
      edst_q   <= '0;
      elen_q   <= '0;
      rdata_q  <= '0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      zl_q     <= zl_d;
      sp_q     <= sp_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      qcnt_q   <= qcnt_d;
      start_q  <= start_d;
      esrc_q   <= esrc_d;
      edst_q   <= edst_d;
      elen_q   <= elen_d;
      rdata_q  <= rdata_d;
    end
  end

  // Descriptor storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {src_q, dst_q, len_q};
  end

  assign avs_readdata    = rdata_q;
  assign avs_waitrequest = 1'b0;
  assign eng_start       = start_q;
  assign eng_src         = esrc_q;
  assign eng_dst         = edst_q;
  assign eng_len         = elen_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_rsa_job_sched.sv
// Bench for rsa_job_sched: directed scenarios then randomized traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_rsa_job_sched;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [1:0]  eng_start;
  logic [31:0] eng_src;
  logic [31:0] eng_dst;
  logic [7:0]  eng_len;
  logic [1:0]  eng_done = '0;
  logic        irq;

  int n_chk = 0;
  int n_bad = 0;

  rsa_job_sched #(.QDEPTH(QD), .NENG(2)) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .eng_start(eng_start), .eng_src(eng_src), .eng_dst(eng_dst), .eng_len(eng_len),
    .eng_done(eng_done), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: jobs in a queue, per-engine busy bits, a pending start.
  typedef struct packed { logic [31:0] s; logic [31:0] d; logic [7:0] l; } desc_t;
  desc_t       mq[$];
  logic [31:0] m_src, m_dst, m_rd;
  logic [7:0]  m_len;
  bit          m_en, m_ien, m_irq, m_ov, m_zl, m_sp, m_pend;
  bit [1:0]    m_busy;
  logic [15:0] m_cnt;
  int          m_rr, m_peng;

  task automatic model_reset();
    mq.delete();
    m_src = 0; m_dst = 0; m_len = 0; m_rd = 0;
    m_en = 0; m_ien = 0; m_irq = 0; m_ov = 0; m_zl = 0; m_sp = 0; m_pend = 0;
    m_busy = 0; m_cnt = 0; m_rr = 0; m_peng = 0;
  endtask

  function automatic logic [31:0] m_status();
    int qn = mq.size();
    return qn + ((qn == QD) << 5) + ((qn == 0) << 6) + (int'(m_busy) << 7)
         + (m_en << 9) + (m_irq << 10) + (m_ov << 11) + (m_zl << 12) + (m_sp << 13);
  endfunction

  task automatic model_step(input bit rst, input bit wr, input logic [2:0] a,
                            input logic [31:0] wd, input bit rd, input logic [1:0] dn);
    int qn, ge, ndone;
    bit go, push, clr;
    if (rst) begin
      model_reset();
      return;
    end
    qn = mq.size();
    if (rd) begin
      case (a)
        0: m_rd = m_src;
        1: m_rd = m_dst;
        2: m_rd = {24'd0, m_len};
        4: m_rd = m_status();
        5: m_rd = {16'd0, m_cnt};
        default: m_rd = 0;
      endcase
    end
    go = !m_pend && m_en && qn > 0 && m_busy != 2'b11;
    ge = m_busy[m_rr] ? 1 - m_rr : m_rr;
    ndone = 0;
    for (int e = 0; e < 2; e++) begin
      if (dn[e]) begin
        if (m_busy[e]) begin m_busy[e] = 0; ndone++; end
        else m_sp = 1'b1;
      end
    end
    if (m_pend) begin
      void'(mq.pop_front());
      m_busy[m_peng] = 1;
      m_rr = 1 - m_peng;
    end
    push = wr && a == 3 && wd[0];
    clr  = wr && a == 3 && wd[2];
    if (clr) begin
      m_cnt = 0; m_irq = 0; m_ov = 0; m_zl = 0;
      m_sp = (dn & ~m_busy_pre(dn)) != 0;
    end
    if (push) begin
      if (m_len == 0) m_zl = 1;
      else if (qn == QD && !m_pend) m_ov = 1;
      else mq.push_back('{s: m_src, d: m_dst, l: m_len});
    end
    m_cnt = m_cnt + 16'(ndone);
    if (ndone > 0 && m_ien) m_irq = 1;
    if (wr) begin
      case (a)
        0: m_src = wd;
        1: m_dst = wd;
        2: m_len = wd[7:0];
        3: begin m_en = wd[1]; m_ien = wd[3]; end
        default: ;
      endcase
    end
    m_pend = go;
    m_peng = ge;
  endtask

  // Busy bits as they were at the start of the step: done clears them, a pop sets one.
  bit [1:0] busy_snap;
  function automatic bit [1:0] m_busy_pre(input logic [1:0] dn);
    return busy_snap;
  endfunction

  task automatic cycle(input bit rst, input bit wr, input logic [2:0] a,
                       input logic [31:0] wd, input bit rd, input logic [1:0] dn);
    @(negedge clk);
    chk("eng_start", 32'(eng_start), m_pend ? (32'd1 << m_peng) : 32'd0);
    if (m_pend) begin
      chk("eng_src", eng_src, mq[0].s);
      chk("eng_dst", eng_dst, mq[0].d);
      chk("eng_len", 32'(eng_len), 32'(mq[0].l));
    end
    chk("irq", 32'(irq), 32'(m_irq));
    chk("readdata", avs_readdata, m_rd);
    chk("waitreq", 32'(avs_waitrequest), 32'd0);
    reset = rst; avs_write = wr; avs_address = a; avs_writedata = wd;
    avs_read = rd; eng_done = dn;
    busy_snap = m_busy;
    model_step(rst, wr, a, wd, rd, dn);
  endtask

  task automatic wreg(input logic [2:0] a, input logic [31:0] d); cycle(0, 1, a, d, 0, 0); endtask
  task automatic rreg(input logic [2:0] a); cycle(0, 0, a, 0, 1, 0); endtask
  task automatic pulse(input logic [1:0] d); cycle(0, 0, 0, 0, 0, d); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0); endtask

  initial begin
    bit en_ph, wr, rd, rst;
    logic [2:0] a;
    logic [31:0] wd;
    logic [1:0] dn;
    int k;
    model_reset();
    busy_snap = 0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("rst_src", eng_src, 32'd0);
    chk("rst_dst", eng_dst, 32'd0);
    chk("rst_len", 32'(eng_len), 32'd0);
    idle(1);
    rreg(4);
    idle(1);
    // basic dispatch
    wreg(3, 32'h2); wreg(0, 32'h100); wreg(1, 32'h200); wreg(2, 32'd3);
    wreg(3, 32'h3); idle(3); rreg(4); idle(1);
    // round-robin with one engine busy
    pulse(2'b01); wreg(2, 32'd5);
    wreg(3, 32'h3); wreg(3, 32'h3); wreg(3, 32'h3); idle(6); rreg(4);
    pulse(2'b10); idle(4); rreg(4); idle(1);
    // irq and counter
    wreg(3, 32'hA); pulse(2'b11); idle(2); rreg(5); rreg(4);
    wreg(3, 32'h6); rreg(5); rreg(4); idle(1);
    // overflow, then simultaneous push/pop while full
    wreg(3, 32'h0);
    for (int i = 0; i < 5; i++) wreg(3, 32'h1);
    rreg(4);
    wreg(3, 32'h2); idle(4); wreg(3, 32'h3); wreg(3, 32'h3); rreg(4);
    pulse(2'b01); idle(1); wreg(3, 32'h3); rreg(4); idle(2); rreg(4);
    // zero length and spurious done
    pulse(2'b11); idle(4); pulse(2'b11); idle(4); pulse(2'b11); idle(3);
    wreg(3, 32'h6); wreg(2, 32'd0); wreg(3, 32'h1); rreg(4);
    pulse(2'b10); rreg(4); rreg(5); idle(1);
    // reset mid-operation
    wreg(2, 32'd7); wreg(3, 32'h3); idle(3); wreg(3, 32'h1); wreg(3, 32'h1);
    rreg(4); cycle(1, 0, 0, 0, 0, 0);
    rreg(4); idle(5); pulse(2'b01); rreg(4); rreg(5);
    // randomized traffic
    en_ph = 1;
    for (int t = 0; t < 4000; t++) begin
      if (t % 250 == 0) en_ph = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 499) == 0;
      wr = 0; a = 3'($urandom_range(0, 7)); wd = $urandom;
      rd = $urandom_range(0, 2) == 0;
      k = $urandom_range(0, 9);
      if (k < 3) begin
        wr = 1; a = 3'($urandom_range(0, 2));
        if (a == 2) wd = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
      end else if (k < 6) begin
        wr = 1; a = 3;
        wd = {28'd0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
              en_ph, 1'($urandom_range(0, 3) != 0)};
      end else if (k == 6) begin
        wr = 1; a = 3'($urandom_range(4, 7));
      end
      dn = {1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0)};
      cycle(rst, wr, a, wd, rd, dn);
    end
    idle(4);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
